shot_controller: RTL and testbench

SHOT_CONTROLLER -- requirements
Module: shot_controller

---
 rtl/shot_controller.sv | 148 ++++++++++++++
 tb/tb_shot_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_controller.sv
// Shot request controller: turns joystick presses into a held shot request, then enforces a tick-based cooldown.
// Optional build macro SHOT_AUTOFIRE_EN: held fire re-issues a shot directly when cooldown expires.
module shot_controller #(
    parameter int         COOLDOWN_TICKS = 4,
    parameter logic [4:0] LFSR_SEED      = 5'h1D
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       tick,
    input  logic       fire,
    input  logic [2:0] player_pos,
    input  logic       shot_ready,
    output logic       shot_valid,
    output logic [2:0] shot_col,
    output logic [4:0] shot_color,
    output logic       cooling,
    output logic [7:0] drop_cnt
);

    // state    | meaning
    // IDLE     | armed, waiting for a press edge while en=1
    // ISSUE    | shot request held until shot_ready handshake
    // COOLDOWN | counting tick strobes before re-arming
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    localparam logic [3:0] CD_INIT = 4'(COOLDOWN_TICKS);

`ifdef SHOT_AUTOFIRE_EN
    localparam logic AUTOFIRE = 1'b1;
`else
    localparam logic AUTOFIRE = 1'b0;
`endif

    state_t     state;
    state_t     state_nx;
    logic       fire_q;
    logic       fire_armed;
    logic       press;
    logic [4:0] lfsr;
    logic [4:0] cap_color;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;
    logic [2:0] col_r;
    logic [2:0] col_nx;
    logic [4:0] color_r;
    logic [4:0] color_nx;
    logic [7:0] drop_r;
    logic       drop_inc;

    // fire_armed blocks a fire held through reset from looking like a fresh press
    assign press     = fire & ~fire_q & fire_armed;
    assign cap_color = 5'd10 + (lfsr % 5'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_q     <= 1'b0;
            fire_armed <= 1'b0;
            lfsr       <= LFSR_SEED;
        end else begin
            fire_q     <= fire;
            fire_armed <= fire_armed | ~fire;
            lfsr       <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            col_r   <= 3'd0;
            color_r <= 5'd0;
            drop_r  <= 8'd0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            col_r   <= col_nx;
            color_r <= color_nx;
            if (drop_inc && (drop_r != 8'hFF)) begin
                drop_r <= drop_r + 8'd1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        col_nx   = col_r;
        color_nx = color_r;
        drop_inc = 1'b0;
        case (state)
            IDLE: begin
                if (en && press) begin
                    state_nx = ISSUE;
                    col_nx   = player_pos;
                    color_nx = cap_color;
                end
            end
            ISSUE: begin
                drop_inc = press;
                if (shot_ready) begin
                    col_nx   = 3'd0;
                    color_nx = 5'd0;
                    if (CD_INIT == 4'd0) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx = COOLDOWN;
                        cnt_nx   = CD_INIT;
                    end
                end
            end
            COOLDOWN: begin
                drop_inc = press;
                if (tick && en) begin
                    if (cnt <= 4'd1) begin
                        cnt_nx   = 4'd0;
                        state_nx = IDLE;
                        if (AUTOFIRE && fire) begin
                            state_nx = ISSUE;
                            col_nx   = player_pos;
                            color_nx = cap_color;
                            drop_inc = 1'b0;
                        end
                    end else begin
                        cnt_nx = cnt - 4'd1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
                col_nx   = 3'd0;
                color_nx = 5'd0;
            end
        endcase
    end

    assign shot_valid = (state == ISSUE);
    assign shot_col   = shot_valid ? col_r : 3'd0;
    assign shot_color = shot_valid ? color_r : 5'd0;
    assign cooling    = (state == COOLDOWN);
    assign drop_cnt   = drop_r;

endmodule

// File: tb/tb_shot_controller.sv
// Self-checking bench for shot_controller: directed scenarios followed by randomized traffic against a behavioural model.
module tb_shot_controller;

    localparam int         CDT  = 4;
    localparam logic [4:0] SEED = 5'h1D;

    logic       clk = 1'b0;
    logic       rst, en, tick, fire, shot_ready;
    logic [2:0] player_pos;
    logic       shot_valid, cooling;
    logic [2:0] shot_col;
    logic [4:0] shot_color;
    logic [7:0] drop_cnt;

    shot_controller #(.COOLDOWN_TICKS(CDT), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .en(en), .tick(tick), .fire(fire),
        .player_pos(player_pos), .shot_ready(shot_ready),
        .shot_valid(shot_valid), .shot_col(shot_col), .shot_color(shot_color),
        .cooling(cooling), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit m_pend, m_prev, m_armed;
    int m_col, m_color, m_cool, m_drops, m_cyc, m_shots;
    int seq [0:30];
    int obs_shots = 0;

    function automatic void build_seq();
        bit b [0:39];
        for (int i = 0; i < 5; i++) b[i] = SEED[4-i];
        for (int n = 0; n < 35; n++) b[n+5] = b[n] ^ b[n+2];
        for (int k = 0; k < 31; k++) begin
            seq[k] = 0;
            for (int i = 0; i < 5; i++) seq[k] = seq[k] * 2 + int'(b[k+i]);
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 0; m_prev = 0; m_armed = 0;
        m_col = 0; m_color = 0; m_cool = 0; m_drops = 0; m_cyc = 0;
    endtask

    task automatic model_drop();
        if (m_drops < 255) m_drops++;
    endtask

    task automatic model_capture(input int lf);
        m_pend  = 1;
        m_col   = int'(player_pos);
        m_color = 10 + lf % 3;
    endtask

    task automatic model_edge();
        bit press;
        bit took;
        int lf;
        press = fire && !m_prev && m_armed;
        lf    = seq[m_cyc % 31];
        took  = 0;
        if (m_pend) begin
            if (press) model_drop();
            if (shot_ready) begin
                m_pend = 0;
                m_shots++;
                m_cool = CDT;
            end
        end else if (m_cool > 0) begin
            if (tick && en) begin
                m_cool--;
`ifdef SHOT_AUTOFIRE_EN
                if (m_cool == 0 && fire) begin
                    model_capture(lf);
                    took = 1;
                end
`endif
            end
            if (press && !took) model_drop();
        end else if (en && press) begin
            model_capture(lf);
        end
        m_armed = m_armed || !fire;
        m_prev  = fire;
        m_cyc++;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(shot_valid), 32'(m_pend));
        check({tag, ".col"}, 32'(shot_col), m_pend ? m_col : 0);
        check({tag, ".color"}, 32'(shot_color), m_pend ? m_color : 0);
        check({tag, ".cooling"}, 32'(cooling), (m_cool > 0 && !m_pend) ? 1 : 0);
        check({tag, ".drops"}, 32'(drop_cnt), m_drops);
    endtask

    task automatic set_in(input bit e, input bit t, input bit f, input bit r, input int p);
        en = e; tick = t; fire = f; shot_ready = r; player_pos = 3'(p);
    endtask

    task automatic step(input string tag);
        if (shot_valid && shot_ready) obs_shots++;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int s0, m0;
        build_seq();
        m_shots = 0;
        set_in(0, 0, 0, 0, 0);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1 check_outputs("reset");
        @(posedge clk);
        #2 rst = 1'b0;

        // press at cycle 5 with ready high: one-cycle shot
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 0, 1, 3);
            step("pre_press");
        end
        set_in(1, 0, 1, 1, 3);
        step("press");
        check("first.valid", 32'(shot_valid), 1);
        check("first.col", 32'(shot_col), 3);
        check("first.color_range", 32'((shot_color >= 5'd10) && (shot_color <= 5'd12)), 1);
        step("first_hs");
        check("first.valid_gone", 32'(shot_valid), 0);
        check("first.cooling", 32'(cooling), 1);
        for (int i = 0; i < 5; i++) begin
            set_in(1, 1, 0, 1, 0);
            step("cool_out");
        end

        // request held through shot_ready=0 while column moves
        set_in(1, 0, 1, 0, 3);
        step("hold_press");
        for (int i = 0; i < 10; i++) begin
            set_in($urandom_range(0, 1), $urandom_range(0, 1), 1, 0, 3 + (i * 3) / 9);
            step("hold");
        end
        check("hold.col", 32'(shot_col), 3);
        s0 = obs_shots;
        set_in(1, 0, 1, 1, 6);
        step("hold_hs");
        set_in(1, 0, 1, 0, 6);
        step("hold_after");
        check("hold.one_hs", obs_shots - s0, 1);
        check("hold.cooling", 32'(cooling), 1);

        // drops during cooldown and tick counting
        do_reset("rst_drop");
        set_in(1, 0, 0, 1, 2);
        step("d_idle");
        set_in(1, 0, 1, 1, 2);
        step("d_press");
        set_in(1, 0, 0, 1, 2);
        step("d_hs");
        for (int i = 0; i < 3; i++) begin
            set_in(1, 0, 1, 1, 2);
            step("d_drop");
            set_in(1, 0, 0, 1, 2);
            step("d_rel");
        end
        check("cool.drops", 32'(drop_cnt), 3);
        set_in(0, 1, 0, 1, 2);
        step("cool_en0");
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 0, 1, 2);
            step("cool_tick");
            set_in(1, 0, 0, 1, 2);
            step("cool_gap");
        end
        check("cool.still", 32'(cooling), 1);
        set_in(1, 1, 0, 1, 2);
        step("cool_last");
        check("cool.done", 32'(cooling), 0);

        // reset mid-ISSUE with fire held
        set_in(1, 0, 0, 0, 5);
        step("r_idle");
        set_in(1, 0, 1, 0, 5);
        step("r_press");
        check("r.valid_pre", 32'(shot_valid), 1);
        s0 = obs_shots;
        do_reset("rst_mid_issue");
        for (int i = 0; i < 6; i++) begin
            set_in(1, 0, 1, 1, 5);
            step("r_held");
        end
        check("r.no_shot", 32'(shot_valid), 0);
        check("r.no_hs", obs_shots - s0, 0);
        set_in(1, 0, 0, 1, 5);
        step("r_rel");
        set_in(1, 0, 1, 1, 1);
        step("r_repress");
        check("r.repress", 32'(shot_valid), 1);
        set_in(1, 0, 0, 1, 1);
        step("r_hs");

        // fire held for 40 cycles, tick every other cycle
        do_reset("rst_auto");
        set_in(1, 0, 0, 1, 4);
        step("a_idle");
        s0 = obs_shots;
        m0 = m_shots;
        for (int i = 0; i < 40; i++) begin
            set_in(1, i % 2, 1, 1, i % 8);
            step("auto");
        end
        set_in(1, 0, 0, 1, 0);
        step("a_end");
        check("auto.shots_model", obs_shots - s0, m_shots - m0);
`ifdef SHOT_AUTOFIRE_EN
        check("auto.repeat", 32'((obs_shots - s0) > 1), 1);
`else
        check("auto.single", obs_shots - s0, 1);
`endif

        // drop counter saturation
        do_reset("rst_sat");
        set_in(1, 0, 0, 0, 7);
        step("s_idle");
        set_in(1, 0, 1, 0, 7);
        step("s_press");
        for (int i = 0; i < 260; i++) begin
            set_in(1, 0, 0, 0, 7);
            step("s_rel");
            set_in(1, 0, 1, 0, 7);
            step("s_drop");
        end
        check("sat.drops", 32'(drop_cnt), 255);
        set_in(1, 0, 0, 1, 7);
        step("s_hs");

        // randomized traffic
        do_reset("rst_rand");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset("rst_rand_mid");
            set_in($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 30,
                   ($urandom_range(0, 2) == 0) ? ~fire : fire,
                   $urandom_range(0, 1), int'($urandom_range(0, 7)));
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
